wb_stage: RTL and testbench

Parametrised successor to the current write-back stage. It accepts one instruction per cycle from execute/memory and selects between the ALU result and load data. It aligns and sign/zero-extends sub-word loads and waits for late memory data through a small state machine. It drives a registered write port that feeds both the register file and data forwarding.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_load_align.sv | 57 +++++
 rtl/wb_stage.sv | 174 +++++++++++++++++
 tb/tb_wb_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: load-size codes and the
// load-wait state machine states.
package wb_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_FULL = 2'b11;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load lane selection and sign/zero extension to D_SIZE.
// Half and word lanes ignore the misaligned low offset bits.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int D_SIZE = 32,
    parameter int OFF_W  = $clog2(D_SIZE/8)
) (
    input  logic [D_SIZE-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic [D_SIZE-1:0] result_o
);

    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [D_SIZE-1:0] lane_b;
    logic [D_SIZE-1:0] lane_h;
    logic [D_SIZE-1:0] lane_w;

    // Keeps the low nbits of f and fills the rest with the field's top bit
    // when sgn is set, zeros otherwise.
    function automatic logic [D_SIZE-1:0] extend_field(
        input logic [D_SIZE-1:0] f,
        input int                nbits,
        input logic              sgn
    );
        logic [D_SIZE-1:0] mask;
        logic              top;
        if (nbits >= D_SIZE) begin
            mask = '1;
        end else begin
            mask = (D_SIZE'(1) << nbits) - D_SIZE'(1);
        end
        top = sgn & (|(f & (mask ^ (mask >> 1))));
        return (f & mask) | ({D_SIZE{top}} & ~mask);
    endfunction

    assign off_h  = off_i & ~OFF_W'(1);
    assign off_w  = off_i & ~OFF_W'(3);

    assign lane_b = data_i >> {off_i, 3'b000};
    assign lane_h = data_i >> {off_h, 3'b000};
    assign lane_w = data_i >> {off_w, 3'b000};

    always_comb begin
        result_o = data_i;
        unique case (size_i)
            LS_BYTE: result_o = extend_field(lane_b, 8, sign_i);
            LS_HALF: result_o = extend_field(lane_h, 16, sign_i);
            LS_WORD: result_o = extend_field(lane_w, 32, sign_i);
            LS_FULL: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU result or aligned load data, waits for late
// memory data, drives the registered write port. Optional WB_STALL_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int D_SIZE   = 32,
    parameter int R_BITS   = 3,
    parameter int OFF_W    = $clog2(D_SIZE/8),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_wb,
    input  logic              reg_we_wb,
    input  logic              load_en_wb,
    input  logic [1:0]        load_size_wb,
    input  logic              load_sign_wb,
    input  logic [OFF_W-1:0]  byte_off_wb,
    input  logic [D_SIZE-1:0] result_wb,
    input  logic [R_BITS-1:0] dest_reg_wb,
    input  logic [D_SIZE-1:0] data_in,
    input  logic              data_in_valid,
    output logic              stall_wb,
    output logic [D_SIZE-1:0] result_rs,
    output logic [R_BITS-1:0] dest_rs,
    output logic              reg_we_rs
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    wb_state_e         state_q, state_d;

    logic [R_BITS-1:0] hold_dest_q;
    logic [1:0]        hold_size_q;
    logic              hold_sign_q;
    logic [OFF_W-1:0]  hold_off_q;
    logic              hold_we_q;

    logic [D_SIZE-1:0] result_q, result_d;
    logic [R_BITS-1:0] dest_q, dest_d;
    logic              we_q, we_d;

    logic              waiting;
    logic              accept;
    logic              load_hit;
    logic              load_miss;
    logic              mem_done;

    logic [1:0]        sel_size;
    logic              sel_sign;
    logic [OFF_W-1:0]  sel_off;
    logic [R_BITS-1:0] sel_dest;
    logic              sel_we;
    logic [D_SIZE-1:0] aligned;

    function automatic logic write_blocked(input logic [R_BITS-1:0] d);
        return (ZERO_REG != 0) && (d == '0);
    endfunction

    always_comb begin
        waiting   = (state_q == WB_WAIT_MEM);
        accept    = !waiting && valid_wb;
        load_hit  = accept && load_en_wb && data_in_valid;
        load_miss = accept && load_en_wb && !data_in_valid;
        mem_done  = waiting && data_in_valid;
    end

    // While waiting, the extractor works from the captured load fields.
    always_comb begin
        sel_size = waiting ? hold_size_q : load_size_wb;
        sel_sign = waiting ? hold_sign_q : load_sign_wb;
        sel_off  = waiting ? hold_off_q  : byte_off_wb;
        sel_dest = waiting ? hold_dest_q : dest_reg_wb;
        sel_we   = waiting ? hold_we_q   : reg_we_wb;
    end

    wb_load_align #(
        .D_SIZE (D_SIZE),
        .OFF_W  (OFF_W)
    ) u_align (
        .data_i   (data_in),
        .size_i   (sel_size),
        .sign_i   (sel_sign),
        .off_i    (sel_off),
        .result_o (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (load_miss) state_d = WB_WAIT_MEM;
            end
            WB_WAIT_MEM: begin
                if (data_in_valid) state_d = WB_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_wb = (state_q == WB_WAIT_MEM);
    end

    always_comb begin
        result_d = result_q;
        dest_d   = dest_q;
        we_d     = 1'b0;
        if (mem_done || load_hit) begin
            result_d = aligned;
            dest_d   = sel_dest;
            we_d     = sel_we && !write_blocked(sel_dest);
        end else if (accept && !load_en_wb) begin
            result_d = result_wb;
            dest_d   = dest_reg_wb;
            we_d     = reg_we_wb && !write_blocked(dest_reg_wb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            dest_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            dest_q   <= dest_d;
            we_q     <= we_d;
        end
    end

    // Holding fields are only meaningful in WAIT_MEM, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_miss) begin
            hold_dest_q <= dest_reg_wb;
            hold_size_q <= load_size_wb;
            hold_sign_q <= load_sign_wb;
            hold_off_q  <= byte_off_wb;
            hold_we_q   <= reg_we_wb;
        end
    end

    assign result_rs = result_q;
    assign dest_rs   = dest_q;
    assign reg_we_rs = we_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_wb) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit ZERO_REG=0 instance and a 64-bit ZERO_REG=1
// instance share stimulus and are compared against a transaction-level model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_wb, reg_we_wb, load_en_wb, load_sign_wb, data_in_valid;
    logic [1:0]  load_size_wb;
    logic [2:0]  byte_off_wb;
    logic [63:0] result_wb, data_in;
    logic [2:0]  dest_reg_wb;

    logic        stall0, stall1, we0, we1;
    logic [31:0] res0;
    logic [63:0] res1;
    logic [2:0]  dst0, dst1;

    int checks = 0;
    int errors = 0;

    bit          pend  [2];
    logic [1:0]  h_size[2];
    logic        h_sign[2];
    logic [2:0]  h_off [2];
    logic [2:0]  h_dest[2];
    logic        h_we  [2];
    logic [63:0] e_res [2];
    logic [2:0]  e_dst [2];
    logic        e_we  [2];

    always #5 clk = ~clk;

    wb_stage #(.D_SIZE(32), .R_BITS(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .valid_wb(valid_wb), .reg_we_wb(reg_we_wb),
        .load_en_wb(load_en_wb), .load_size_wb(load_size_wb), .load_sign_wb(load_sign_wb),
        .byte_off_wb(byte_off_wb[1:0]), .result_wb(result_wb[31:0]), .dest_reg_wb(dest_reg_wb),
        .data_in(data_in[31:0]), .data_in_valid(data_in_valid), .stall_wb(stall0),
        .result_rs(res0), .dest_rs(dst0), .reg_we_rs(we0)
    );

    wb_stage #(.D_SIZE(64), .R_BITS(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .valid_wb(valid_wb), .reg_we_wb(reg_we_wb),
        .load_en_wb(load_en_wb), .load_size_wb(load_size_wb), .load_sign_wb(load_sign_wb),
        .byte_off_wb(byte_off_wb), .result_wb(result_wb), .dest_reg_wb(dest_reg_wb),
        .data_in(data_in), .data_in_valid(data_in_valid), .stall_wb(stall1),
        .result_rs(res1), .dest_rs(dst1), .reg_we_rs(we1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loaded value from the size/sign/offset rules, truncated to width w.
    function automatic logic [63:0] extract(input logic [63:0] d, input logic [1:0] sz,
                                            input logic sg, input logic [2:0] off, input int w);
        int          nb, pos, o;
        logic [63:0] m, f;
        o = int'(off);
        case (sz)
            2'd0:    begin nb = 8;  pos = 8 * o;           end
            2'd1:    begin nb = 16; pos = 8 * ((o / 2) * 2); end
            2'd2:    begin nb = 32; pos = 8 * ((o / 4) * 4); end
            default: begin nb = w;  pos = 0;               end
        endcase
        m = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
        f = (d >> pos) & m;
        if (sg && (((f >> (nb - 1)) & 64'd1) != 64'd0)) f = f | ~m;
        if (w == 32) f = f & 64'hFFFF_FFFF;
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; e_res[k] = '0; e_dst[k] = '0; e_we[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic [63:0] d, r, cd;
            logic [2:0]  o, cdst;
            bit          cm, cwe;
            w  = (k == 1) ? 64 : 32;
            d  = (k == 1) ? data_in   : {32'h0, data_in[31:0]};
            r  = (k == 1) ? result_wb : {32'h0, result_wb[31:0]};
            o  = (k == 1) ? byte_off_wb : {1'b0, byte_off_wb[1:0]};
            cm = 0; cwe = 0; cd = '0; cdst = '0;
            if (pend[k]) begin
                if (data_in_valid) begin
                    cm = 1; cd = extract(d, h_size[k], h_sign[k], h_off[k], w);
                    cdst = h_dest[k]; cwe = h_we[k]; pend[k] = 0;
                end
            end else if (valid_wb) begin
                if (!load_en_wb) begin
                    cm = 1; cd = r; cdst = dest_reg_wb; cwe = reg_we_wb;
                end else if (data_in_valid) begin
                    cm = 1; cd = extract(d, load_size_wb, load_sign_wb, o, w);
                    cdst = dest_reg_wb; cwe = reg_we_wb;
                end else begin
                    pend[k] = 1; h_size[k] = load_size_wb; h_sign[k] = load_sign_wb;
                    h_off[k] = o; h_dest[k] = dest_reg_wb; h_we[k] = reg_we_wb;
                end
            end
            if (cm) begin
                e_res[k] = cd; e_dst[k] = cdst;
                e_we[k]  = cwe && !((k == 1) && (cdst == 3'd0));
            end else begin
                e_we[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        chk("stall0", 64'(stall0), 64'(pend[0]));
        chk("stall1", 64'(stall1), 64'(pend[1]));
        @(posedge clk);
        #1;
        model_edge();
        chk("res0", 64'(res0), e_res[0]);
        chk("dst0", 64'(dst0), 64'(e_dst[0]));
        chk("we0",  64'(we0),  64'(e_we[0]));
        chk("res1", res1, e_res[1]);
        chk("dst1", 64'(dst1), 64'(e_dst[1]));
        chk("we1",  64'(we1),  64'(e_we[1]));
    endtask

    task automatic idle_in();
        valid_wb = 0; reg_we_wb = 0; load_en_wb = 0; load_size_wb = 2'd0; load_sign_wb = 0;
        byte_off_wb = '0; result_wb = '0; dest_reg_wb = '0; data_in = '0; data_in_valid = 0;
    endtask

    task automatic alu(input logic [63:0] r, input logic [2:0] d, input logic we);
        valid_wb = 1; load_en_wb = 0; result_wb = r; dest_reg_wb = d; reg_we_wb = we;
        data_in_valid = 0;
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [2:0] off,
                        input logic [2:0] d, input logic we, input logic [63:0] data, input logic dv);
        valid_wb = 1; load_en_wb = 1; load_size_wb = sz; load_sign_wb = sg; byte_off_wb = off;
        dest_reg_wb = d; reg_we_wb = we; data_in = data; data_in_valid = dv; result_wb = '0;
    endtask

    initial begin
        int stall_cycles;
        idle_in();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res0", 64'(res0), 64'd0);
        chk("rst_we0", 64'(we0), 64'd0);
        chk("rst_stall0", 64'(stall0), 64'd0);
        rst = 1'b0;

        alu(64'h1234_5678, 3'd5, 1'b1);
        step();
        chk("alu_res", 64'(res0), 64'h1234_5678);
        chk("alu_dst", 64'(dst0), 64'd5);
        chk("alu_we", 64'(we0), 64'd1);
        idle_in();
        step();
        chk("alu_pulse", 64'(we0), 64'd0);
        chk("alu_hold", 64'(res0), 64'h1234_5678);

        load(2'd0, 1'b1, 3'd3, 3'd2, 1'b1, 64'h80FF_7F01, 1'b1);
        step();
        chk("ldb_sign", 64'(res0), 64'hFFFF_FF80);
        load(2'd0, 1'b0, 3'd3, 3'd2, 1'b1, 64'h80FF_7F01, 1'b1);
        step();
        chk("ldb_zero", 64'(res0), 64'h0000_0080);
        load(2'd1, 1'b1, 3'd1, 3'd1, 1'b1, 64'h8001_1234, 1'b1);
        step();
        chk("ldh_off", 64'(res0), 64'h0000_1234);
        load(2'd2, 1'b1, 3'd5, 3'd1, 1'b1, 64'h8765_4321_0000_0000, 1'b1);
        step();
        chk("ldw_64", res1, 64'hFFFF_FFFF_8765_4321);

        // Delayed load with an ALU op queued behind it
        load(2'd2, 1'b0, 3'd0, 3'd4, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        step();
        alu(64'h55, 3'd6, 1'b1);
        data_in = 64'hDEAD_BEEF_CAFE_F00D;
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall0) stall_cycles++;
            data_in_valid = (i == 2);
            step();
        end
        chk("dly_stall_len", 64'(stall_cycles), 64'd3);
        chk("dly_res", 64'(res0), 64'hCAFE_F00D);
        chk("dly_we", 64'(we0), 64'd1);
        chk("dly_dst", 64'(dst0), 64'd4);
        chk("dly_unstall", 64'(stall0), 64'd0);
        data_in_valid = 0;
        step();
        chk("dly_alu_res", 64'(res0), 64'h55);
        chk("dly_alu_dst", 64'(dst0), 64'd6);

        alu(64'h99, 3'd0, 1'b1);
        step();
        chk("zr_we", 64'(we1), 64'd0);
        chk("zr_dst", 64'(dst1), 64'd0);
        chk("zr_res", res1, 64'h99);
        chk("nz_we", 64'(we0), 64'd1);

        load(2'd3, 1'b0, 3'd0, 3'd7, 1'b0, 64'h0, 1'b0);
        step();
        idle_in();
        data_in = 64'h0123_4567_89AB_CDEF;
        data_in_valid = 1;
        step();
        chk("nowe_we", 64'(we0), 64'd0);
        chk("nowe_res", 64'(res0), 64'h89AB_CDEF);

        // Reset while waiting for load data
        load(2'd0, 1'b0, 3'd0, 3'd3, 1'b1, 64'h0, 1'b0);
        step();
        chk("mid_stall", 64'(stall0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_res", 64'(res0), 64'd0);
        chk("mid_dst", 64'(dst0), 64'd0);
        chk("mid_we", 64'(we0), 64'd0);
        chk("mid_stall_clr", 64'(stall0), 64'd0);
        chk("mid_stall_clr1", 64'(stall1), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_in();
        data_in = 64'hFF;
        data_in_valid = 1;
        step();
        chk("mid_nowrite", 64'(we0), 64'd0);

        for (int n = 0; n < 600; n++) begin
            valid_wb      = ($urandom_range(0, 3) != 0);
            load_en_wb    = $urandom_range(0, 1) == 1;
            load_size_wb  = 2'($urandom_range(0, 3));
            load_sign_wb  = $urandom_range(0, 1) == 1;
            byte_off_wb   = 3'($urandom_range(0, 7));
            dest_reg_wb   = 3'($urandom_range(0, 7));
            reg_we_wb     = ($urandom_range(0, 3) != 0);
            result_wb     = {$urandom, $urandom};
            data_in       = {$urandom, $urandom};
            data_in_valid = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
